econet_line_controller: RTL and testbench
=========================================

// Module: econet_line_controller
// PURPOSE
//  Sequences the econet transceiver datapath between receive and transmit. Watches the raw
//  econet clock/data lines, grants transmit (mcu_is_transmitting) only on a clocked, idle line,
//  detects collisions while driving, and enforces a post-frame holdoff before the next grant.
//  Sits between the MCU's frame-request line and the econet datapath's direction input.
// PARAMETERS
//  IDLE_BITS       15      consecutive 1s sampled on data_R (econet clock rising edges) => line idle
//  CLOCK_TIMEOUT   2400    clock_24m cycles with no econet clock rising edge => clock absent (100us)
//  WAIT_TIMEOUT    240000  max clock_24m cycles spent waiting for idle before tx_fail (10ms)
//  HOLDOFF_CYCLES  480     clock_24m cycles forced receive after any TX end/abort (20us)
// PORTS
//  clock_24m            in   1  system clock, 24 MHz
//  reset_n              in   1  synchronous reset, active low
//  tx_request           in   1  MCU wants to send a frame; level, held until frame done
//  econet_clock_R       in   1  raw econet clock receiver output (async)
//  econet_data_R        in   1  raw econet data receiver output (async)
//  econet_data_D        in   1  data the datapath is driving
//  econet_data_DE       in   1  datapath data driver enable
//  outputting_frame     in   1  datapath still shifting a frame out
//  mcu_is_transmitting  out  1  direction select to datapath (1 = TX)
//  line_idle            out  1  IDLE_BITS or more consecutive 1s seen
//  clock_present        out  1  econet clock edge seen within CLOCK_TIMEOUT
//  tx_fail              out  1  one-cycle pulse: grant refused (timeout / no clock / clock lost in TX)
//  collision            out  1  one-cycle pulse: driven bit != received bit
//  ctrl_state           out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset (reset_n=0 at clock edge): all outputs 0, state RX, all counters 0, sync flops 1.
//  Reset mid-frame drops mcu_is_transmitting the cycle after the reset edge; no pulses issued.
//  Line sampling: clock_R, data_R through 2-FF synchronisers; econet rising edge = sync 0->1.
//  Idle counter: on each rising edge, data=1 -> increment (saturate at IDLE_BITS), data=0 -> 0.
//  line_idle = (count == IDLE_BITS); registered, valid 1 cycle after the deciding edge.
//  Clock timer: cleared on each rising edge, saturating increment otherwise;
//   clock_present = (timer < CLOCK_TIMEOUT); on loss, idle counter also cleared.
//  States (ctrl_state): RX=0, WAIT_IDLE=1, TX=2, HOLDOFF=3.
//   RX: tx_request & line_idle & clock_present -> TX (grant next cycle);
//       tx_request & !clock_present -> tx_fail pulse, stay RX until tx_request drops;
//       tx_request otherwise -> WAIT_IDLE, wait counter cleared.
//   WAIT_IDLE: line_idle & clock_present -> TX; wait counter reaches WAIT_TIMEOUT -> tx_fail, RX;
//       tx_request dropped -> RX (no pulse).
//   TX: mcu_is_transmitting=1. Collision -> collision pulse, HOLDOFF. clock_present falls ->
//       tx_fail pulse, HOLDOFF. !tx_request & !outputting_frame -> HOLDOFF.
//   HOLDOFF: mcu_is_transmitting=0, tx_request ignored; after HOLDOFF_CYCLES -> RX.
//  After a tx_fail in RX/WAIT_IDLE, new grant only after tx_request seen low (edge re-arm).
//  Collision check: data_D, data_DE delayed 2 cycles to match sync latency; on each econet rising
//   edge in TX, delayed DE=1 and delayed D != synced data_R => collision.
//  Priority same cycle: reset > collision > clock loss > normal end of frame.
//  Counters saturate; no wrap. Pulses never asserted in consecutive cycles.
// STRUCTURE
//  Shared package econet_pkg: state localparams (RX/WAIT_IDLE/TX/HOLDOFF), default timing constants.
//  Sub-module econet_line_monitor: synchronisers, edge detect, idle counter, clock timer;
//   outputs rise_pulse, data_sync, line_idle, clock_present. FSM and collision logic stay top-level.
// TESTING
//  Bench: 24MHz clock, econet clock 1us high/4us low, data changes on econet clock fall.
//  1 Reset with data=1: line_idle at 15th rising edge +1 cycle, not 14th; tx_request then ->
//    mcu_is_transmitting=1 within 2 cycles, ctrl_state=2.
//  2 tx_request while data toggles 0/1: ctrl_state=1; hold data busy 10ms -> single tx_fail pulse,
//    state 0, no grant until tx_request low then high on an idle line.
//  3 Stop econet clock: clock_present falls after 2400 cycles; request -> tx_fail, no grant;
//    stop clock during TX -> tx_fail, grant drops, ctrl_state=3 for 480 cycles then 0.
//  4 In TX drive data_D=1, DE=1, force data_R=0 -> one collision pulse at next econet rising
//    edge, grant drops, HOLDOFF 480 cycles; tx_request held high not re-granted before that.
//  5 Normal frame: drop tx_request while outputting_frame=1 -> grant held until it falls,
//    then HOLDOFF; assert reset_n=0 mid-TX -> all outputs 0 next cycle, no pulses.

Source files
------------

// File: rtl/econet_pkg.sv
// Shared definitions for the econet line controller: controller state encoding
// and the default line timing constants (in 24 MHz clock cycles / econet bits).
`timescale 1ns/1ps

package econet_pkg;

    localparam int DEF_IDLE_BITS      = 15;
    localparam int DEF_CLOCK_TIMEOUT  = 2400;
    localparam int DEF_WAIT_TIMEOUT   = 240000;
    localparam int DEF_HOLDOFF_CYCLES = 480;

    typedef enum logic [2:0] {
        ST_RX        = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_TX        = 3'd2,
        ST_HOLDOFF   = 3'd3
    } ctrl_state_t;

endpackage

// File: rtl/econet_line_monitor.sv
// Watches the raw econet clock/data lines: synchronises them, finds econet clock
// rising edges, and derives the registered line_idle and clock_present flags.
`timescale 1ns/1ps

import econet_pkg::*;

module econet_line_monitor #(
    parameter int IDLE_BITS     = DEF_IDLE_BITS,
    parameter int CLOCK_TIMEOUT = DEF_CLOCK_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic econet_clock_i,
    input  logic econet_data_i,
    output logic rise_pulse_o,
    output logic data_sync_o,
    output logic line_idle_o,
    output logic clock_present_o
);

    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam int TW = $clog2(CLOCK_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_BITS);
    localparam logic [TW-1:0] TIME_MAX = TW'(CLOCK_TIMEOUT);

    logic          clk_s1_q, clk_s2_q, clk_s3_q;
    logic          dat_s1_q, dat_s2_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          line_idle_q, clock_present_q;
    logic          rise_s;

    assign rise_s          = clk_s2_q & ~clk_s3_q;
    assign rise_pulse_o    = rise_s;
    assign data_sync_o     = dat_s2_q;
    assign line_idle_o     = line_idle_q;
    assign clock_present_o = clock_present_q;

    // Next-state for the idle bit counter and the clock-absence timer
    always_comb begin
        timer_d = timer_q;
        idle_d  = idle_q;
        if (rise_s) begin
            timer_d = '0;
            if (dat_s2_q) begin
                idle_d = (idle_q == IDLE_MAX) ? idle_q : idle_q + IW'(1);
            end else begin
                idle_d = '0;
            end
        end else begin
            timer_d = (timer_q == TIME_MAX) ? timer_q : timer_q + TW'(1);
            // a dead clock means the idle history is no longer trustworthy
            if (timer_d == TIME_MAX) begin
                idle_d = '0;
            end else begin
                idle_d = idle_q;
            end
        end
    end

    // Synchronisers, counters and registered line flags
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            clk_s1_q        <= 1'b1;
            clk_s2_q        <= 1'b1;
            clk_s3_q        <= 1'b1;
            dat_s1_q        <= 1'b1;
            dat_s2_q        <= 1'b1;
            idle_q          <= '0;
            timer_q         <= '0;
            line_idle_q     <= 1'b0;
            clock_present_q <= 1'b0;
        end else begin
            clk_s1_q        <= econet_clock_i;
            clk_s2_q        <= clk_s1_q;
            clk_s3_q        <= clk_s2_q;
            dat_s1_q        <= econet_data_i;
            dat_s2_q        <= dat_s1_q;
            idle_q          <= idle_d;
            timer_q         <= timer_d;
            line_idle_q     <= (idle_d == IDLE_MAX);
            clock_present_q <= (timer_d != TIME_MAX);
        end
    end

endmodule

// File: rtl/econet_line_controller.sv
// Econet line controller: grants transmit direction on a clocked idle line,
// aborts on collision or clock loss, and forces a receive holdoff after each frame.
`timescale 1ns/1ps

import econet_pkg::*;

module econet_line_controller #(
    parameter int IDLE_BITS      = DEF_IDLE_BITS,
    parameter int CLOCK_TIMEOUT  = DEF_CLOCK_TIMEOUT,
    parameter int WAIT_TIMEOUT   = DEF_WAIT_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
    input  logic       clock_24m,
    input  logic       reset_n,
    input  logic       tx_request,
    input  logic       econet_clock_R,
    input  logic       econet_data_R,
    input  logic       econet_data_D,
    input  logic       econet_data_DE,
    input  logic       outputting_frame,
    output logic       mcu_is_transmitting,
    output logic       line_idle,
    output logic       clock_present,
    output logic       tx_fail,
    output logic       collision,
    output logic [2:0] ctrl_state
);

    localparam int WW = $clog2(WAIT_TIMEOUT + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(WAIT_TIMEOUT);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

    ctrl_state_t   state_q;
    logic          mcu_tx_q, tx_fail_q, collision_q, armed_q;
    logic [WW-1:0] wait_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic [1:0]    d_dly_q, de_dly_q;
    logic          rise_s, data_sync_s, line_idle_s, clock_present_s, collide_s;

    econet_line_monitor #(
        .IDLE_BITS     (IDLE_BITS),
        .CLOCK_TIMEOUT (CLOCK_TIMEOUT)
    ) u_monitor (
        .clk_i           (clock_24m),
        .rst_n_i         (reset_n),
        .econet_clock_i  (econet_clock_R),
        .econet_data_i   (econet_data_R),
        .rise_pulse_o    (rise_s),
        .data_sync_o     (data_sync_s),
        .line_idle_o     (line_idle_s),
        .clock_present_o (clock_present_s)
    );

    // Driven data/enable delayed to line up with the receive synchroniser
    always_ff @(posedge clock_24m) begin
        if (!reset_n) begin
            d_dly_q  <= 2'b00;
            de_dly_q <= 2'b00;
        end else begin
            d_dly_q  <= {d_dly_q[0], econet_data_D};
            de_dly_q <= {de_dly_q[0], econet_data_DE};
        end
    end

    assign collide_s = (state_q == ST_TX) & rise_s & de_dly_q[1] & (d_dly_q[1] ^ data_sync_s);

    // Direction FSM with registered grant and one-cycle status pulses
    always_ff @(posedge clock_24m) begin
        if (!reset_n) begin
            state_q     <= ST_RX;
            mcu_tx_q    <= 1'b0;
            tx_fail_q   <= 1'b0;
            collision_q <= 1'b0;
            armed_q     <= 1'b1;
            wait_cnt_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            tx_fail_q   <= 1'b0;
            collision_q <= 1'b0;
            case (state_q)
                ST_RX: begin
                    mcu_tx_q <= 1'b0;
                    if (!tx_request) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        if (line_idle_s && clock_present_s) begin
                            state_q  <= ST_TX;
                            mcu_tx_q <= 1'b1;
                        end else if (!clock_present_s) begin
                            tx_fail_q <= 1'b1;
                            armed_q   <= 1'b0;
                        end else begin
                            state_q    <= ST_WAIT_IDLE;
                            wait_cnt_q <= '0;
                        end
                    end else begin
                        state_q <= ST_RX;
                    end
                end
                ST_WAIT_IDLE: begin
                    mcu_tx_q <= 1'b0;
                    if (!tx_request) begin
                        state_q <= ST_RX;
                    end else if (line_idle_s && clock_present_s) begin
                        state_q  <= ST_TX;
                        mcu_tx_q <= 1'b1;
                    end else if (wait_cnt_q == WAIT_MAX) begin
                        state_q   <= ST_RX;
                        tx_fail_q <= 1'b1;
                        armed_q   <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                ST_TX: begin
                    // collision outranks clock loss, which outranks a normal end
                    if (collide_s) begin
                        collision_q <= 1'b1;
                        state_q     <= ST_HOLDOFF;
                        mcu_tx_q    <= 1'b0;
                        hold_cnt_q  <= '0;
                    end else if (!clock_present_s) begin
                        tx_fail_q  <= 1'b1;
                        state_q    <= ST_HOLDOFF;
                        mcu_tx_q   <= 1'b0;
                        hold_cnt_q <= '0;
                    end else if (!tx_request && !outputting_frame) begin
                        state_q    <= ST_HOLDOFF;
                        mcu_tx_q   <= 1'b0;
                        hold_cnt_q <= '0;
                    end else begin
                        mcu_tx_q <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    mcu_tx_q <= 1'b0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= ST_RX;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: begin
                    state_q  <= ST_RX;
                    mcu_tx_q <= 1'b0;
                end
            endcase
        end
    end

    assign mcu_is_transmitting = mcu_tx_q;
    assign line_idle           = line_idle_s;
    assign clock_present       = clock_present_s;
    assign tx_fail             = tx_fail_q;
    assign collision           = collision_q;
    assign ctrl_state          = state_q;

endmodule

// File: tb/tb_econet_line_controller.sv
// Directed bench for econet_line_controller: 24 MHz system clock, econet clock
// 1us high / 4us low, line data updated on econet clock falling edges.
`timescale 1ns/1ps

module tb_econet_line_controller;

    logic       clock_24m = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_request = 1'b0;
    logic       econet_clock_R = 1'b0;
    logic       econet_data_R = 1'b1;
    logic       econet_data_D = 1'b0;
    logic       econet_data_DE = 1'b0;
    logic       outputting_frame = 1'b0;
    logic       mcu_is_transmitting, line_idle, clock_present, tx_fail, collision;
    logic [2:0] ctrl_state;

    int checks = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fail_cnt = 0;
    int coll_cnt = 0;
    int consec_cnt = 0;
    int data_mode = 0;     // 0: line held 1, 1: toggles, 2: forced 0
    bit econ_run = 1'b1;
    bit prev_fail = 1'b0;
    bit prev_coll = 1'b0;

    // WAIT_TIMEOUT shortened so the busy-line timeout happens in a few thousand cycles
    econet_line_controller #(
        .IDLE_BITS      (15),
        .CLOCK_TIMEOUT  (2400),
        .WAIT_TIMEOUT   (3000),
        .HOLDOFF_CYCLES (480)
    ) dut (
        .clock_24m           (clock_24m),
        .reset_n             (reset_n),
        .tx_request          (tx_request),
        .econet_clock_R      (econet_clock_R),
        .econet_data_R       (econet_data_R),
        .econet_data_D       (econet_data_D),
        .econet_data_DE      (econet_data_DE),
        .outputting_frame    (outputting_frame),
        .mcu_is_transmitting (mcu_is_transmitting),
        .line_idle           (line_idle),
        .clock_present       (clock_present),
        .tx_fail             (tx_fail),
        .collision           (collision),
        .ctrl_state          (ctrl_state)
    );

    initial forever #20.833 clock_24m = ~clock_24m;

    initial forever begin
        if (econ_run) begin
            econet_clock_R = 1'b1;
            rise_cnt++;
            #1000;
            econet_clock_R = 1'b0;
            #4000;
        end else begin
            #1000;
        end
    end

    initial forever begin
        @(negedge econet_clock_R);
        case (data_mode)
            0: econet_data_R = 1'b1;
            1: econet_data_R = ~econet_data_R;
            default: econet_data_R = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clock_24m);
        if (tx_fail === 1'b1) fail_cnt++;
        if (collision === 1'b1) coll_cnt++;
        if ((tx_fail === 1'b1 && prev_fail) || (collision === 1'b1 && prev_coll)) consec_cnt++;
        prev_fail = (tx_fail === 1'b1);
        prev_coll = (collision === 1'b1);
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clock_24m);
    endtask

    task automatic wait_rises(input int n);
        int target;
        int budget;
        target = rise_cnt + n;
        budget = n * 200;
        while (rise_cnt < target && budget > 0) begin
            @(negedge clock_24m);
            budget--;
        end
        checks++;
        if (rise_cnt < target) begin
            failures++;
            $display("FAIL wait_rises: got %0d econet edges, need %0d", rise_cnt, target);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        clks(4);
        checks++;
        if ({mcu_is_transmitting, line_idle, clock_present, tx_fail, collision} !== 5'b00000 ||
            ctrl_state !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: got mcu=%b idle=%b clk=%b fail=%b coll=%b st=%0d, need all 0",
                     mcu_is_transmitting, line_idle, clock_present, tx_fail, collision, ctrl_state);
        end
        @(negedge econet_clock_R);
        @(negedge clock_24m);
        reset_n = 1'b1;
        wait_rises(14);
        clks(20);
        checks++;
        if (line_idle !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_14: got %b need 0", line_idle);
        end
        wait_rises(1);
        clks(10);
        checks++;
        if (line_idle !== 1'b1 || clock_present !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_15: got idle=%b clk=%b need 1 1", line_idle, clock_present);
        end
        tx_request = 1'b1;
        clks(2);
        checks++;
        if (mcu_is_transmitting !== 1'b1 || ctrl_state !== 3'd2) begin
            failures++;
            $display("FAIL first_grant: got mcu=%b st=%0d need 1 2", mcu_is_transmitting, ctrl_state);
        end
        tx_request = 1'b0;
        clks(500);
        checks++;
        if (ctrl_state !== 3'd0 || mcu_is_transmitting !== 1'b0) begin
            failures++;
            $display("FAIL back_to_rx: got st=%0d mcu=%b need 0 0", ctrl_state, mcu_is_transmitting);
        end
    endtask

    task automatic test_wait_timeout;
        int base;
        data_mode = 1;
        wait_rises(3);
        clks(10);
        checks++;
        if (line_idle !== 1'b0) begin
            failures++;
            $display("FAIL busy_not_idle: got %b need 0", line_idle);
        end
        base = fail_cnt;
        tx_request = 1'b1;
        clks(2);
        checks++;
        if (ctrl_state !== 3'd1) begin
            failures++;
            $display("FAIL wait_state: got %0d need 1", ctrl_state);
        end
        clks(3050);
        checks++;
        if (fail_cnt != base + 1 || ctrl_state !== 3'd0 || mcu_is_transmitting !== 1'b0) begin
            failures++;
            $display("FAIL wait_timeout: got pulses=%0d st=%0d mcu=%b need %0d 0 0",
                     fail_cnt - base, ctrl_state, mcu_is_transmitting, 1);
        end
        data_mode = 0;
        wait_rises(16);
        clks(10);
        checks++;
        if (line_idle !== 1'b1 || mcu_is_transmitting !== 1'b0 || fail_cnt != base + 1) begin
            failures++;
            $display("FAIL no_rearm: got idle=%b mcu=%b pulses=%0d need 1 0 1",
                     line_idle, mcu_is_transmitting, fail_cnt - base);
        end
        tx_request = 1'b0;
        clks(2);
        tx_request = 1'b1;
        clks(3);
        checks++;
        if (mcu_is_transmitting !== 1'b1 || ctrl_state !== 3'd2) begin
            failures++;
            $display("FAIL rearm_grant: got mcu=%b st=%0d need 1 2", mcu_is_transmitting, ctrl_state);
        end
        tx_request = 1'b0;
        clks(500);
    endtask

    task automatic test_clock_loss;
        int base;
        wait_rises(1);
        econ_run = 1'b0;
        clks(2300);
        checks++;
        if (clock_present !== 1'b1) begin
            failures++;
            $display("FAIL clock_still_present: got %b need 1", clock_present);
        end
        clks(150);
        checks++;
        if (clock_present !== 1'b0 || line_idle !== 1'b0) begin
            failures++;
            $display("FAIL clock_lost: got clk=%b idle=%b need 0 0", clock_present, line_idle);
        end
        base = fail_cnt;
        tx_request = 1'b1;
        clks(12);
        checks++;
        if (fail_cnt != base + 1 || mcu_is_transmitting !== 1'b0 || ctrl_state !== 3'd0) begin
            failures++;
            $display("FAIL noclk_request: got pulses=%0d mcu=%b st=%0d need 1 0 0",
                     fail_cnt - base, mcu_is_transmitting, ctrl_state);
        end
        tx_request = 1'b0;
        econ_run = 1'b1;
        wait_rises(16);
        clks(10);
        tx_request = 1'b1;
        outputting_frame = 1'b1;
        clks(3);
        checks++;
        if (mcu_is_transmitting !== 1'b1) begin
            failures++;
            $display("FAIL regrant: got %b need 1", mcu_is_transmitting);
        end
        base = fail_cnt;
        wait_rises(1);
        econ_run = 1'b0;
        clks(2450);
        checks++;
        if (fail_cnt != base + 1 || mcu_is_transmitting !== 1'b0 || ctrl_state !== 3'd3) begin
            failures++;
            $display("FAIL tx_clock_loss: got pulses=%0d mcu=%b st=%0d need 1 0 3",
                     fail_cnt - base, mcu_is_transmitting, ctrl_state);
        end
        tx_request = 1'b0;
        outputting_frame = 1'b0;
        clks(380);
        checks++;
        if (ctrl_state !== 3'd3) begin
            failures++;
            $display("FAIL holdoff_hold: got %0d need 3", ctrl_state);
        end
        clks(100);
        checks++;
        if (ctrl_state !== 3'd0) begin
            failures++;
            $display("FAIL holdoff_end: got %0d need 0", ctrl_state);
        end
        econ_run = 1'b1;
    endtask

    task automatic test_collision;
        int base;
        int grants;
        wait_rises(16);
        clks(10);
        tx_request = 1'b1;
        outputting_frame = 1'b1;
        clks(3);
        checks++;
        if (mcu_is_transmitting !== 1'b1) begin
            failures++;
            $display("FAIL coll_grant: got %b need 1", mcu_is_transmitting);
        end
        base = coll_cnt;
        wait_rises(1);
        econet_data_D = 1'b1;
        econet_data_DE = 1'b1;
        data_mode = 2;
        wait_rises(1);
        clks(10);
        checks++;
        if (coll_cnt != base + 1 || mcu_is_transmitting !== 1'b0 || ctrl_state !== 3'd3) begin
            failures++;
            $display("FAIL collision: got pulses=%0d mcu=%b st=%0d need 1 0 3",
                     coll_cnt - base, mcu_is_transmitting, ctrl_state);
        end
        grants = 0;
        for (int i = 0; i < 460; i++) begin
            @(negedge clock_24m);
            if (mcu_is_transmitting !== 1'b0) grants++;
        end
        checks++;
        if (grants != 0) begin
            failures++;
            $display("FAIL holdoff_regrant: got %0d granted cycles need 0", grants);
        end
        clks(60);
        checks++;
        if (ctrl_state !== 3'd1 || coll_cnt != base + 1) begin
            failures++;
            $display("FAIL after_collision: got st=%0d pulses=%0d need 1 1", ctrl_state, coll_cnt - base);
        end
        tx_request = 1'b0;
        outputting_frame = 1'b0;
        econet_data_D = 1'b0;
        econet_data_DE = 1'b0;
        data_mode = 0;
        clks(3);
    endtask

    task automatic test_normal_frame_and_reset;
        int fbase;
        int cbase;
        wait_rises(16);
        clks(10);
        tx_request = 1'b1;
        outputting_frame = 1'b1;
        clks(3);
        tx_request = 1'b0;
        clks(50);
        checks++;
        if (mcu_is_transmitting !== 1'b1 || ctrl_state !== 3'd2) begin
            failures++;
            $display("FAIL frame_hold: got mcu=%b st=%0d need 1 2", mcu_is_transmitting, ctrl_state);
        end
        outputting_frame = 1'b0;
        clks(2);
        checks++;
        if (mcu_is_transmitting !== 1'b0 || ctrl_state !== 3'd3) begin
            failures++;
            $display("FAIL frame_end: got mcu=%b st=%0d need 0 3", mcu_is_transmitting, ctrl_state);
        end
        clks(480);
        checks++;
        if (ctrl_state !== 3'd0) begin
            failures++;
            $display("FAIL frame_holdoff: got %0d need 0", ctrl_state);
        end
        tx_request = 1'b1;
        outputting_frame = 1'b1;
        clks(3);
        fbase = fail_cnt;
        cbase = coll_cnt;
        reset_n = 1'b0;
        clks(1);
        checks++;
        if ({mcu_is_transmitting, line_idle, clock_present, tx_fail, collision} !== 5'b00000 ||
            ctrl_state !== 3'd0) begin
            failures++;
            $display("FAIL mid_tx_reset: got mcu=%b idle=%b clk=%b fail=%b coll=%b st=%0d need all 0",
                     mcu_is_transmitting, line_idle, clock_present, tx_fail, collision, ctrl_state);
        end
        tx_request = 1'b0;
        outputting_frame = 1'b0;
        clks(3);
        reset_n = 1'b1;
        clks(5);
        checks++;
        if (fail_cnt != fbase || coll_cnt != cbase || consec_cnt != 0) begin
            failures++;
            $display("FAIL pulse_hygiene: got fail=%0d coll=%0d consecutive=%0d need 0 0 0",
                     fail_cnt - fbase, coll_cnt - cbase, consec_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_wait_timeout();
        test_clock_loss();
        test_collision();
        test_normal_frame_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
